// File: rtl/spi_slave_if.sv
// Bus bundle between the SPI responder and its surroundings: SPI pins plus the
// CPU-side data/status words.
interface spi_slave_if;
  logic        SCLK;
  logic        MOSI;
  logic        SS;
  logic        MISO;
  logic        miso_oe;
  logic        wordsize;
  logic [31:0] dataTx;
  logic        load;
  logic        txrdy;
  logic [31:0] dataRx;
  logic        rdy;
  logic        done;
  logic        ovr;

  modport slave (
    input  SCLK, MOSI, SS, wordsize, dataTx, load, done,
    output MISO, miso_oe, txrdy, dataRx, rdy, ovr
  );

  modport master (
    output SCLK, MOSI, SS, wordsize, dataTx, load, done,
    input  MISO, miso_oe, txrdy, dataRx, rdy, ovr
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8- or 32-bit words. SCLK/MOSI/SS are
// oversampled in the clk domain; CPU side mirrors the SPI master's data/status words.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      rst,
  spi_slave_if.slave bus
);

  typedef enum logic [1:0] {
    WAITHI = 2'd0,
    IDLE   = 2'd1,
    LOAD   = 2'd2,
    SHIFT  = 2'd3
  } state_t;

  state_t state_r, state_next_s;

  logic [SYNC_STAGES-1:0] sclk_sync_r, mosi_sync_r, ss_sync_r;
  logic        sclk_prev_r, mosi_prev_r, ss_prev_r;
  logic        sclk_s, ss_s, sclk_rise_s, sclk_fall_s, ss_fall_s;
  logic        ws_r;
  logic [4:0]  cnt_r, last_cnt_s;
  logic [31:0] shift_r, txbuf_r, data_rx_r, shifted_s, reload_s;
  logic        txrdy_r, rdy_r, ovr_r, miso_r, miso_oe_r;
  logic        load_state_s, word_done_s, consume_s;

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign ss_s        = ss_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_s & sclk_prev_r;
  assign ss_fall_s   = ~ss_s & ss_prev_r;

  assign load_state_s = (state_r == LOAD);
  assign last_cnt_s   = ws_r ? 5'd31 : 5'd7;
  assign shifted_s    = {shift_r[30:0], mosi_prev_r};
  assign word_done_s  = (state_r == SHIFT) && !ss_s && sclk_rise_s && (cnt_r == last_cnt_s);
  // Holding register is handed to the shifter at SS fall and at every word boundary.
  assign consume_s    = (load_state_s || word_done_s) && !txrdy_r;
  assign reload_s     = txrdy_r ? 32'hFFFF_FFFF : txbuf_r;

  // Input synchronisers followed by one edge-detect register per pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      ss_sync_r   <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
      mosi_prev_r <= 1'b0;
      ss_prev_r   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.SCLK};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.MOSI};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], bus.SS};
      sclk_prev_r <= sclk_s;
      mosi_prev_r <= mosi_sync_r[SYNC_STAGES-1];
      ss_prev_r   <= ss_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= WAITHI;
    else     state_r <= state_next_s;
  end

  // FSM next-state logic; WAITHI keeps us from joining a transfer mid-word.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WAITHI: if (ss_s) state_next_s = IDLE;  else state_next_s = WAITHI;
      IDLE:   if (ss_fall_s) state_next_s = LOAD; else state_next_s = IDLE;
      LOAD:   state_next_s = SHIFT;
      SHIFT:  if (ss_s) state_next_s = IDLE;  else state_next_s = SHIFT;
      default: state_next_s = WAITHI;
    endcase
  end

  // Shift datapath and MISO driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_r      <= 1'b0;
      cnt_r     <= 5'd0;
      shift_r   <= 32'd0;
      miso_r    <= 1'b1;
      miso_oe_r <= 1'b0;
    end else begin
      miso_oe_r <= (state_next_s == LOAD) || (state_next_s == SHIFT);
      if (load_state_s) begin
        ws_r    <= bus.wordsize;
        cnt_r   <= 5'd0;
        shift_r <= reload_s;
        miso_r  <= bus.wordsize ? reload_s[31] : reload_s[7];
      end else if ((state_r == SHIFT) && !ss_s) begin
        if (sclk_rise_s) begin
          if (word_done_s) begin
            shift_r <= reload_s;
            cnt_r   <= 5'd0;
          end else begin
            shift_r <= shifted_s;
            cnt_r   <= cnt_r + 5'd1;
          end
        end else if (sclk_fall_s) begin
          miso_r <= ws_r ? shift_r[31] : shift_r[7];
        end
      end
    end
  end

  // CPU-side holding/status registers; a fresh load wins over a same-clk consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      txbuf_r   <= 32'd0;
      txrdy_r   <= 1'b1;
      data_rx_r <= 32'd0;
      rdy_r     <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      if (bus.load) begin
        txbuf_r <= bus.dataTx;
        txrdy_r <= 1'b0;
      end else if (consume_s) begin
        txrdy_r <= 1'b1;
      end
      if (word_done_s) begin
        data_rx_r <= ws_r ? shifted_s : {24'd0, shifted_s[7:0]};
        rdy_r     <= 1'b1;
      end else if (bus.done) begin
        rdy_r <= 1'b0;
      end
      if (word_done_s && rdy_r && !bus.done) ovr_r <= 1'b1;
      else if (bus.done && !word_done_s)     ovr_r <= 1'b0;
    end
  end

  assign bus.MISO    = miso_r;
  assign bus.miso_oe = miso_oe_r;
  assign bus.txrdy   = txrdy_r;
  assign bus.dataRx  = data_rx_r;
  assign bus.rdy     = rdy_r;
  assign bus.ovr     = ovr_r;

endmodule
